// File: rtl/mips_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_div_unit_pkg
//  Description : Shared state encoding, latency and result-field offsets for
//                the iterative MIPS divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_div_unit_pkg;

    localparam int DIV_DW      = 32;
    localparam int DIV_LATENCY = DIV_DW + 1;
    localparam int QUO_LSB     = DIV_DW;
    localparam int REM_LSB     = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_div_unit_if
//  Description : Divisor/dividend valid-ready request channels and the
//                result channel between the execute stage and the divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_div_unit_if #(
    parameter int DW = 32
);
    logic              s_axis_divisor_tvalid;
    logic              s_axis_divisor_tready;
    logic [DW-1:0]     s_axis_divisor_tdata;
    logic              s_axis_dividend_tvalid;
    logic              s_axis_dividend_tready;
    logic [DW-1:0]     s_axis_dividend_tdata;
    logic              m_axis_dout_tvalid;
    logic [2*DW-1:0]   m_axis_dout_tdata;

    // Execute-stage side
    modport master (
        output s_axis_divisor_tvalid, s_axis_divisor_tdata,
        output s_axis_dividend_tvalid, s_axis_dividend_tdata,
        input  s_axis_divisor_tready, s_axis_dividend_tready,
        input  m_axis_dout_tvalid, m_axis_dout_tdata
    );

    // Divider side
    modport slave (
        input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
        input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
        output s_axis_divisor_tready, s_axis_dividend_tready,
        output m_axis_dout_tvalid, m_axis_dout_tdata
    );
endinterface
`default_nettype wire

// File: rtl/mips_div_unit_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : mips_div_unit_div_step
//  Description : One restoring shift-subtract step on unsigned magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_div_unit_div_step #(
    parameter int DW = 32
) (
    input  wire [DW:0]   i_rem,
    input  wire [DW-1:0] i_dvs,
    input  wire          i_bit,
    output logic [DW:0]  o_rem,
    output logic         o_qbit
);
    logic [DW+1:0] w_shift;
    logic [DW+1:0] w_diff;

    // Shift in the next dividend bit, trial-subtract, keep the difference
    // only when it did not go negative (sign bit of the widened difference).
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {2'b00, i_dvs};
        o_qbit  = ~w_diff[DW+1];
        o_rem   = (DW+1)'(o_qbit ? w_diff : w_shift);
    end
endmodule
`default_nettype wire

// File: rtl/mips_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mips_div_unit
//  Description : Multi-cycle restoring divider, DIV (SIGNED=1) or DIVU
//                (SIGNED=0). Returns {quotient, remainder} with a one-cycle
//                valid pulse. Optional macro DIV_EARLY_OUT_EN skips the loop
//                when divisor==0 or |dividend| < |divisor|.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_div_unit
    import mips_div_unit_pkg::*;
#(
    parameter int SIGNED = 1,
    parameter int DW     = DIV_DW
) (
    input  wire              clk,
    input  wire              resetn,
    mips_div_unit_if.slave   div_bus
);
    localparam int CW = $clog2(DW);

    div_state_t        r_state;
    logic [DW-1:0]     r_dvd;      // dividend magnitude, shifts into quotient
    logic [DW-1:0]     r_dvs;
    logic [DW:0]       r_rem;
    logic [CW-1:0]     r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div0;
    logic              r_tvalid;
    logic [2*DW-1:0]   r_tdata;

    logic              w_ready;
    logic              w_accept;
    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [DW-1:0]     w_dvd_mag;
    logic [DW-1:0]     w_dvs_mag;
    logic              w_dvs_zero;
    logic              w_early;
    logic [DW:0]       w_step_rem;
    logic              w_qbit;
    logic [DW-1:0]     w_quo_raw;
    logic [DW-1:0]     w_quo_fix;
    logic [DW-1:0]     w_rem_fix;

    assign w_ready  = (r_state == DIV_IDLE) && resetn;
    assign w_accept = w_ready && div_bus.s_axis_divisor_tvalid
                              && div_bus.s_axis_dividend_tvalid;

    assign div_bus.s_axis_divisor_tready  = w_ready;
    assign div_bus.s_axis_dividend_tready = w_ready;
    assign div_bus.m_axis_dout_tvalid     = r_tvalid;
    assign div_bus.m_axis_dout_tdata      = r_tdata;

    // Operand signs and magnitudes at the input; 0x80000000 maps to 2^31.
    always_comb begin
        w_dvd_neg  = (SIGNED != 0) && div_bus.s_axis_dividend_tdata[DW-1];
        w_dvs_neg  = (SIGNED != 0) && div_bus.s_axis_divisor_tdata[DW-1];
        w_dvd_mag  = w_dvd_neg ? -div_bus.s_axis_dividend_tdata
                               :  div_bus.s_axis_dividend_tdata;
        w_dvs_mag  = w_dvs_neg ? -div_bus.s_axis_divisor_tdata
                               :  div_bus.s_axis_divisor_tdata;
        w_dvs_zero = (div_bus.s_axis_divisor_tdata == '0);
    end

`ifdef DIV_EARLY_OUT_EN
    assign w_early = w_dvs_zero || (w_dvd_mag < w_dvs_mag);
`else
    assign w_early = 1'b0;
`endif

    mips_div_unit_div_step #(.DW(DW)) u_step (
        .i_rem  (r_rem),
        .i_dvs  (r_dvs),
        .i_bit  (r_dvd[DW-1]),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    // Final-step sign fix-up. With a zero divisor the loop reproduces the
    // dividend magnitude as remainder, so re-applying the dividend sign
    // returns the dividend unchanged; only the quotient needs overriding.
    always_comb begin
        w_quo_raw = {r_dvd[DW-2:0], w_qbit};
        w_quo_fix = r_div0  ? {DW{1'b1}} : (r_neg_q ? -w_quo_raw : w_quo_raw);
        w_rem_fix = r_neg_r ? -w_step_rem[DW-1:0] : w_step_rem[DW-1:0];
    end

    // Control FSM and datapath: accept, iterate DW steps, pulse result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= DIV_IDLE;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_dvd   <= w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_rem   <= '0;
                        r_cnt   <= CW'(DW-1);
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_div0  <= w_dvs_zero;
                        if (w_early) begin
                            r_state  <= DIV_DONE;
                            r_tvalid <= 1'b1;
                            r_tdata  <= {(w_dvs_zero ? {DW{1'b1}} : {DW{1'b0}}),
                                         div_bus.s_axis_dividend_tdata};
                        end else begin
                            r_state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    r_rem <= w_step_rem;
                    r_dvd <= w_quo_raw;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state  <= DIV_DONE;
                        r_tvalid <= 1'b1;
                        r_tdata  <= {w_quo_fix, w_rem_fix};
                    end
                end
                DIV_DONE: begin
                    r_state  <= DIV_IDLE;
                    r_tvalid <= 1'b0;
                end
                default: begin
                    r_state  <= DIV_IDLE;
                    r_tvalid <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_div_unit
//  Description : Directed self-checking bench for signed and unsigned
//                instances of mips_div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_div_unit;
    localparam int FULL_LAT = 33;
`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_DIV0 = 1;
`else
    localparam int LAT_DIV0 = 33;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic sel = 1'b1;            // 1 = signed instance, 0 = unsigned instance
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mips_div_unit_if #(.DW(32)) ifs ();
    mips_div_unit_if #(.DW(32)) ifu ();

    mips_div_unit #(.SIGNED(1), .DW(32)) u_dut_s (.clk(clk), .resetn(resetn), .div_bus(ifs));
    mips_div_unit #(.SIGNED(0), .DW(32)) u_dut_u (.clk(clk), .resetn(resetn), .div_bus(ifu));

    logic        w_ready;
    logic        w_tvalid;
    logic [63:0] w_tdata;
    assign w_ready  = sel ? ifs.s_axis_divisor_tready : ifu.s_axis_divisor_tready;
    assign w_tvalid = sel ? ifs.m_axis_dout_tvalid   : ifu.m_axis_dout_tvalid;
    assign w_tdata  = sel ? ifs.m_axis_dout_tdata    : ifu.m_axis_dout_tdata;

    task automatic drive(input logic vs, input logic vd, input logic [31:0] dvs, input logic [31:0] dvd);
        if (sel) begin
            ifs.s_axis_divisor_tvalid = vs;  ifs.s_axis_divisor_tdata  = dvs;
            ifs.s_axis_dividend_tvalid = vd; ifs.s_axis_dividend_tdata = dvd;
        end else begin
            ifu.s_axis_divisor_tvalid = vs;  ifu.s_axis_divisor_tdata  = dvs;
            ifu.s_axis_dividend_tvalid = vd; ifu.s_axis_dividend_tdata = dvd;
        end
    endtask

    // Issues one op and watches 40 cycles; lat is the cycle index (accept edge = T,
    // first sample = cycle T+1) of the first valid, rdy counts tready highs up to it.
    task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs,
                          output logic [63:0] res, output int lat, output int nv, output int rdy);
        int guard = 0;
        res = '0; lat = -1; nv = 0; rdy = 0;
        while (!w_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        drive(1'b1, 1'b1, dvs, dvd);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        for (int i = 0; i < 40; i++) begin
            if (w_tvalid) begin
                nv++;
                if (lat < 0) begin lat = i + 1; res = w_tdata; end
            end
            if (w_ready && (lat < 0 || lat == i + 1)) rdy++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (ifs.s_axis_divisor_tready !== 1'b0 || ifs.s_axis_dividend_tready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready_s got %b/%b want 0/0", ifs.s_axis_divisor_tready, ifs.s_axis_dividend_tready); end
        n_cmp++; if (ifu.s_axis_divisor_tready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready_u got %b want 0", ifu.s_axis_divisor_tready); end
        n_cmp++; if (ifs.m_axis_dout_tvalid !== 1'b0 || ifu.m_axis_dout_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL reset_tvalid got %b/%b want 0/0", ifs.m_axis_dout_tvalid, ifu.m_axis_dout_tvalid); end
        n_cmp++; if (ifs.m_axis_dout_tdata !== 64'h0 || ifu.m_axis_dout_tdata !== 64'h0) begin
            n_bad++; $display("FAIL reset_tdata got %h/%h want 0", ifs.m_axis_dout_tdata, ifu.m_axis_dout_tdata); end
        @(posedge clk); #1; resetn = 1'b1; #1;
        n_cmp++; if (ifs.s_axis_divisor_tready !== 1'b1 || ifu.s_axis_dividend_tready !== 1'b1) begin
            n_bad++; $display("FAIL idle_ready got %b/%b want 1/1", ifs.s_axis_divisor_tready, ifu.s_axis_dividend_tready); end
    endtask

    task automatic test_signed_basic;
        logic [63:0] res; int lat, nv, rdy;
        sel = 1'b1;
        run_op(32'd7, 32'd2, res, lat, nv, rdy);
        n_cmp++; if (res !== {32'd3, 32'd1}) begin n_bad++; $display("FAIL s_7_2 got %h want %h", res, {32'd3, 32'd1}); end
        n_cmp++; if (lat !== FULL_LAT) begin n_bad++; $display("FAIL s_7_2_lat got %0d want %0d", lat, FULL_LAT); end
        n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL s_7_2_pulses got %0d want 1", nv); end
        n_cmp++; if (rdy !== 0) begin n_bad++; $display("FAIL s_7_2_busy_ready got %0d want 0", rdy); end
        n_cmp++; if (w_tdata !== {32'd3, 32'd1}) begin n_bad++; $display("FAIL s_7_2_hold got %h want %h", w_tdata, {32'd3, 32'd1}); end
        run_op(32'hFFFF_FFF9, 32'd2, res, lat, nv, rdy);
        n_cmp++; if (res !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
            n_bad++; $display("FAIL s_m7_2 got %h want %h", res, {32'hFFFF_FFFD, 32'hFFFF_FFFF}); end
        n_cmp++; if (lat !== FULL_LAT) begin n_bad++; $display("FAIL s_m7_2_lat got %0d want %0d", lat, FULL_LAT); end
    endtask

    task automatic test_wide_operands;
        logic [63:0] res; int lat, nv, rdy;
        sel = 1'b0;
        run_op(32'hFFFF_FFFF, 32'h10, res, lat, nv, rdy);
        n_cmp++; if (res !== {32'h0FFF_FFFF, 32'hF}) begin n_bad++; $display("FAIL u_ffff_10 got %h want %h", res, {32'h0FFF_FFFF, 32'hF}); end
        n_cmp++; if (lat !== FULL_LAT) begin n_bad++; $display("FAIL u_ffff_10_lat got %0d want %0d", lat, FULL_LAT); end
        sel = 1'b1;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, res, lat, nv, rdy);
        n_cmp++; if (res !== {32'h8000_0000, 32'h0}) begin n_bad++; $display("FAIL s_min_m1 got %h want %h", res, {32'h8000_0000, 32'h0}); end
    endtask

    task automatic test_div_zero;
        logic [63:0] res; int lat, nv, rdy;
        sel = 1'b1;
        run_op(32'h1234, 32'h0, res, lat, nv, rdy);
        n_cmp++; if (res !== {32'hFFFF_FFFF, 32'h1234}) begin n_bad++; $display("FAIL s_div0 got %h want %h", res, {32'hFFFF_FFFF, 32'h1234}); end
        n_cmp++; if (lat !== LAT_DIV0) begin n_bad++; $display("FAIL s_div0_lat got %0d want %0d", lat, LAT_DIV0); end
        sel = 1'b0;
        run_op(32'h1234, 32'h0, res, lat, nv, rdy);
        n_cmp++; if (res !== {32'hFFFF_FFFF, 32'h1234}) begin n_bad++; $display("FAIL u_div0 got %h want %h", res, {32'hFFFF_FFFF, 32'h1234}); end
        n_cmp++; if (lat !== LAT_DIV0) begin n_bad++; $display("FAIL u_div0_lat got %0d want %0d", lat, LAT_DIV0); end
        n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL u_div0_pulses got %0d want 1", nv); end
    endtask

    task automatic test_single_valid;
        int bad = 0; int lat = -1; logic [63:0] res = '0;
        sel = 1'b1;
        drive(1'b1, 1'b0, 32'd3, 32'd50);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!w_ready || w_tvalid) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL single_valid_accepted got %0d bad cycles want 0", bad); end
        drive(1'b1, 1'b1, 32'd3, 32'd50);
        @(posedge clk); #1;
        n_cmp++; if (w_ready !== 1'b0) begin n_bad++; $display("FAIL both_valid_accept got ready=%b want 0", w_ready); end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (w_tvalid && lat < 0) begin lat = i + 1; res = w_tdata; end
            @(posedge clk); #1;
        end
        n_cmp++; if (res !== {32'd16, 32'd2} || lat !== FULL_LAT) begin
            n_bad++; $display("FAIL s_50_3 got %h lat %0d want %h lat %0d", res, lat, {32'd16, 32'd2}, FULL_LAT); end
    endtask

    task automatic test_reset_mid_calc;
        logic [63:0] res; int lat, nv, rdy; int pulses = 0;
        sel = 1'b1;
        drive(1'b1, 1'b1, 32'd3, 32'd200);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #1; resetn = 1'b0; #1;
        n_cmp++; if (w_ready !== 1'b0 || w_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_outputs got ready=%b tvalid=%b want 0/0", w_ready, w_tvalid); end
        @(posedge clk); #1; resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (w_tvalid) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mid_reset_discard got %0d pulses want 0", pulses); end
        run_op(32'd100, 32'd7, res, lat, nv, rdy);
        n_cmp++; if (res !== {32'd14, 32'd2} || lat !== FULL_LAT) begin
            n_bad++; $display("FAIL post_reset_100_7 got %h lat %0d want %h lat %0d", res, lat, {32'd14, 32'd2}, FULL_LAT); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] r1 = '0; logic [63:0] r2 = '0;
        int d1 = -1; int d2 = -1; int acc2 = -1; int nv = 0; int hold_bad = 0;
        logic drop = 1'b0;
        sel = 1'b1;
        drive(1'b1, 1'b1, 32'd10, 32'd1000);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 32'd7, 32'hFFFF_FC18);
        for (int i = 0; i < 80; i++) begin
            if (drop) begin drive(1'b0, 1'b0, 32'd0, 32'd0); drop = 1'b0; end
            if (w_tvalid) begin
                nv++;
                if (d1 < 0) begin d1 = i + 1; r1 = w_tdata; end
                else if (d2 < 0) begin d2 = i + 1; r2 = w_tdata; end
            end else if (d1 >= 0 && d2 < 0 && w_tdata !== r1) begin
                hold_bad++;
            end
            if (w_ready && acc2 < 0) begin acc2 = i + 1; drop = 1'b1; end
            @(posedge clk); #1;
        end
        n_cmp++; if (r1 !== {32'd100, 32'd0} || d1 !== FULL_LAT) begin
            n_bad++; $display("FAIL b2b_first got %h at %0d want %h at %0d", r1, d1, {32'd100, 32'd0}, FULL_LAT); end
        n_cmp++; if (acc2 !== FULL_LAT + 1) begin n_bad++; $display("FAIL b2b_second_accept got %0d want %0d", acc2, FULL_LAT + 1); end
        n_cmp++; if (r2 !== {32'hFFFF_FF72, 32'hFFFF_FFFA} || d2 !== 2 * FULL_LAT + 1) begin
            n_bad++; $display("FAIL b2b_second got %h at %0d want %h at %0d", r2, d2, {32'hFFFF_FF72, 32'hFFFF_FFFA}, 2 * FULL_LAT + 1); end
        n_cmp++; if (hold_bad !== 0 || nv !== 2) begin
            n_bad++; $display("FAIL b2b_hold got %0d unstable cycles %0d pulses want 0 and 2", hold_bad, nv); end
    endtask

    initial begin
        sel = 1'b1; drive(1'b0, 1'b0, 32'd0, 32'd0);
        sel = 1'b0; drive(1'b0, 1'b0, 32'd0, 32'd0);
        sel = 1'b1;
        #1;
        test_reset;
        test_signed_basic;
        test_wide_operands;
        test_div_zero;
        test_single_valid;
        test_reset_mid_calc;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
